alu_exec: RTL

- Execution-side receiver of the reservation station's arithmetic issue interface: the RS presents at most one ready operation per cycle as ari_ins_flag, ari_insty, ari_val1, ari_val2 and ari_ROB_idx.
- Computes the RV32I integer result, branch condition or JALR target for that operation.
- Registers the result and drives it one cycle later as the broadcast that the RS, LSB and ROB snoop (val_flag_RS / val_idx_RS / val_RS).
- Also keeps an issued-operation counter for performance debug.

---
 rtl/alu_exec_pkg.sv | 46 ++++
 rtl/alu_exec_core.sv | 64 ++++++
 rtl/alu_exec.sv | 96 +++++++++
 3 files changed

// File: rtl/alu_exec_pkg.sv
// Shared widths, instruction-type codes and helper types for the arithmetic execution path.
// The codes match the ones used by the decoder and the reservation station.
package alu_exec_pkg;

    localparam int RLEN = 32;
    localparam int RBID = 4;
    localparam int ILEN = 6;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam logic [ILEN-1:0] INS_ADD   = 6'd1;
    localparam logic [ILEN-1:0] INS_SUB   = 6'd2;
    localparam logic [ILEN-1:0] INS_AND   = 6'd3;
    localparam logic [ILEN-1:0] INS_OR    = 6'd4;
    localparam logic [ILEN-1:0] INS_XOR   = 6'd5;
    localparam logic [ILEN-1:0] INS_SLL   = 6'd6;
    localparam logic [ILEN-1:0] INS_SRL   = 6'd7;
    localparam logic [ILEN-1:0] INS_SRA   = 6'd8;
    localparam logic [ILEN-1:0] INS_SLT   = 6'd9;
    localparam logic [ILEN-1:0] INS_SLTU  = 6'd10;
    localparam logic [ILEN-1:0] INS_ADDI  = 6'd11;
    localparam logic [ILEN-1:0] INS_ANDI  = 6'd12;
    localparam logic [ILEN-1:0] INS_ORI   = 6'd13;
    localparam logic [ILEN-1:0] INS_XORI  = 6'd14;
    localparam logic [ILEN-1:0] INS_SLLI  = 6'd15;
    localparam logic [ILEN-1:0] INS_SRLI  = 6'd16;
    localparam logic [ILEN-1:0] INS_SRAI  = 6'd17;
    localparam logic [ILEN-1:0] INS_SLTI  = 6'd18;
    localparam logic [ILEN-1:0] INS_SLTIU = 6'd19;
    localparam logic [ILEN-1:0] INS_LUI   = 6'd20;
    localparam logic [ILEN-1:0] INS_BEQ   = 6'd21;
    localparam logic [ILEN-1:0] INS_BNE   = 6'd22;
    localparam logic [ILEN-1:0] INS_BLT   = 6'd23;
    localparam logic [ILEN-1:0] INS_BGE   = 6'd24;
    localparam logic [ILEN-1:0] INS_BLTU  = 6'd25;
    localparam logic [ILEN-1:0] INS_BGEU  = 6'd26;
    localparam logic [ILEN-1:0] INS_JALR  = 6'd27;

    typedef struct packed {
        logic [RLEN-1:0] result;
        logic            is_branch;
        logic            cond;
    } alu_res_t;

endpackage

// File: rtl/alu_exec_core.sv
// Combinational RV32I integer datapath: result value, branch marker and branch condition
// as a pure function of the instruction type and the two operands.
module alu_core
    import alu_exec_pkg::*;
(
    input  logic [ILEN-1:0] insty,
    input  logic [RLEN-1:0] val1,
    input  logic [RLEN-1:0] val2,
    output alu_res_t        res
);

    logic [RLEN-1:0] sum;
    logic [RLEN-1:0] diff;
    logic [4:0]      shamt;
    logic            lt_s;
    logic            lt_u;
    logic            eq;

    assign sum   = val1 + val2;
    assign diff  = val1 - val2;
    assign shamt = val2[4:0];
    assign lt_s  = $signed(val1) < $signed(val2);
    assign lt_u  = val1 < val2;
    assign eq    = val1 == val2;

    always_comb begin
        res.result    = '0;
        res.is_branch = FALSE;
        res.cond      = FALSE;
        case (insty)
            INS_ADD, INS_ADDI:   res.result = sum;
            INS_SUB:             res.result = diff;
            INS_AND, INS_ANDI:   res.result = val1 & val2;
            INS_OR,  INS_ORI:    res.result = val1 | val2;
            INS_XOR, INS_XORI:   res.result = val1 ^ val2;
            INS_SLL, INS_SLLI:   res.result = val1 << shamt;
            INS_SRL, INS_SRLI:   res.result = val1 >> shamt;
            INS_SRA, INS_SRAI:   res.result = $unsigned($signed(val1) >>> shamt);
            INS_SLT, INS_SLTI:   res.result = {{(RLEN-1){1'b0}}, lt_s};
            INS_SLTU, INS_SLTIU: res.result = {{(RLEN-1){1'b0}}, lt_u};
            INS_LUI:             res.result = val2;
            INS_BEQ, INS_BNE, INS_BLT, INS_BGE, INS_BLTU, INS_BGEU: begin
                res.is_branch = TRUE;
                case (insty)
                    INS_BEQ:  res.cond = eq;
                    INS_BNE:  res.cond = !eq;
                    INS_BLT:  res.cond = lt_s;
                    INS_BGE:  res.cond = !lt_s;
                    INS_BLTU: res.cond = lt_u;
                    default:  res.cond = !lt_u;
                endcase
                res.result = {{(RLEN-1){1'b0}}, res.cond};
            end
            INS_JALR: begin
                // Target LSB is forced to zero as JALR requires.
                res.result    = {sum[RLEN-1:1], 1'b0};
                res.is_branch = TRUE;
                res.cond      = TRUE;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_exec.sv
// Arithmetic execution unit: accepts one RS issue per cycle, computes it in alu_core and
// broadcasts the registered result one cycle later; also counts accepted operations.
module alu_exec
    import alu_exec_pkg::*;
#(
    parameter int RLEN_W = RLEN,
    parameter int RBID_W = RBID,
    parameter int ILEN_W = ILEN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rdy,
    input  logic              jp_wrong,
    input  logic              ari_ins_flag,
    input  logic [ILEN_W-1:0] ari_insty,
    input  logic [RLEN_W-1:0] ari_val1,
    input  logic [RLEN_W-1:0] ari_val2,
    input  logic [RBID_W-1:0] ari_ROB_idx,
    output logic              val_flag_RS,
    output logic [RBID_W-1:0] val_idx_RS,
    output logic [RLEN_W-1:0] val_RS,
    output logic              br_flag,
    output logic              br_taken,
    output logic [31:0]       op_count
);

    alu_res_t          core_res;

    logic              flag_q,     flag_d;
    logic [RBID_W-1:0] idx_q,      idx_d;
    logic [RLEN_W-1:0] val_q,      val_d;
    logic              br_flag_q,  br_flag_d;
    logic              br_taken_q, br_taken_d;
    logic [31:0]       count_q,    count_d;

    alu_core u_core (
        .insty (ari_insty),
        .val1  (ari_val1),
        .val2  (ari_val2),
        .res   (core_res)
    );

    // Priority: flush, then stall (everything holds), then accept or idle.
    always_comb begin
        flag_d     = flag_q;
        idx_d      = idx_q;
        val_d      = val_q;
        br_flag_d  = br_flag_q;
        br_taken_d = br_taken_q;
        count_d    = count_q;
        if (jp_wrong) begin
            flag_d     = FALSE;
            br_flag_d  = FALSE;
            br_taken_d = FALSE;
        end else if (rdy) begin
            if (ari_ins_flag) begin
                flag_d     = TRUE;
                idx_d      = ari_ROB_idx;
                val_d      = core_res.result;
                br_flag_d  = core_res.is_branch;
                br_taken_d = core_res.cond;
                count_d    = count_q + 32'd1;
            end else begin
                flag_d     = FALSE;
                br_flag_d  = FALSE;
                br_taken_d = FALSE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_q     <= FALSE;
            idx_q      <= '0;
            val_q      <= '0;
            br_flag_q  <= FALSE;
            br_taken_q <= FALSE;
            count_q    <= '0;
        end else begin
            flag_q     <= flag_d;
            idx_q      <= idx_d;
            val_q      <= val_d;
            br_flag_q  <= br_flag_d;
            br_taken_q <= br_taken_d;
            count_q    <= count_d;
        end
    end

    assign val_flag_RS = flag_q;
    assign val_idx_RS  = idx_q;
    assign val_RS      = val_q;
    assign br_flag     = br_flag_q;
    assign br_taken    = br_taken_q;
    assign op_count    = count_q;

endmodule
